// File: rtl/iecdrv_pkg.sv
// Shared types for the IEC drive SD block-request arbiter.
package iecdrv_pkg;

   localparam int NDR_MAX = 4;

   typedef logic [1:0] drv_idx_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_XFER,
      ARB_DONE
   } arb_state_t;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Round-robin picker: the first set request bit strictly after 'last', wrapping at NDR.
module iecdrv_rr_pick
   import iecdrv_pkg::*;
#(
   parameter int NDR = 4
) (
   input  logic [NDR-1:0] req,
   input  drv_idx_t       last,
   output logic           hit,
   output drv_idx_t       idx
);

   int w_cand;

   // Walk from the farthest candidate to the nearest so the nearest eligible drive wins.
   always_comb begin
      hit    = 1'b0;
      idx    = last;
      w_cand = 0;
      for (int k = NDR; k >= 1; k--) begin
         w_cand = int'(last) + k;
         if (w_cand >= NDR) begin
            w_cand = w_cand - NDR;
         end
         if (req[w_cand]) begin
            hit = 1'b1;
            idx = w_cand[1:0];
         end
      end
   end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Merges per-drive SD sector requests onto one host block channel, one transaction
// at a time, round-robin, with per-drive reset masking of the acknowledge.
module iecdrv_sd_arbiter
   import iecdrv_pkg::*;
#(
   parameter int NDR   = 4,
   parameter int LBA_W = 32
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic [NDR-1:0]       drv_reset,
   input  logic [NDR*LBA_W-1:0] drv_lba,
   input  logic [NDR-1:0]       drv_rd,
   input  logic [NDR-1:0]       drv_wr,
   output logic [NDR-1:0]       drv_ack,
   input  logic [NDR*8-1:0]     drv_buff_din,
   output logic [LBA_W-1:0]     host_lba,
   output logic                 host_rd,
   output logic                 host_wr,
   input  logic                 host_ack,
   output logic [7:0]           host_buff_din,
   output logic                 busy
);

   arb_state_t       r_state;
   drv_idx_t         r_grant;
   logic [LBA_W-1:0] r_lba;
   logic             r_host_rd;
   logic             r_host_wr;
   logic             r_abort;
   logic [NDR-1:0]   r_drv_ack;

   logic [NDR-1:0]   w_elig;
   logic [NDR-1:0]   w_ack_vec;
   logic             w_hit;
   logic             w_active;
   logic             w_abort;
   logic             w_pick_wr;
   drv_idx_t         w_pick;
   logic [LBA_W-1:0] w_lba_arr [NDR];
   logic [7:0]       w_din_arr [NDR];

   // Unpack the flat per-drive buses and build the acknowledge pattern for the granted drive.
   generate
      for (genvar gi = 0; gi < NDR; gi++) begin : g_drv
         assign w_lba_arr[gi] = drv_lba[gi*LBA_W +: LBA_W];
         assign w_din_arr[gi] = drv_buff_din[gi*8 +: 8];
         assign w_ack_vec[gi] = (r_grant == drv_idx_t'(gi)) & ~w_abort;
      end
   endgenerate

   // A drive held in reset never wins arbitration.
   assign w_elig    = (drv_rd | drv_wr) & ~drv_reset;
   assign w_pick_wr = drv_wr[w_pick];
   assign w_active  = (r_state == ARB_REQ) || (r_state == ARB_XFER);

   // Abort is sticky for the rest of the transaction; the host side still runs to completion.
   assign w_abort   = r_abort | (w_active & drv_reset[r_grant]);

   iecdrv_rr_pick #(
      .NDR (NDR)
   ) u_pick (
      .req  (w_elig),
      .last (r_grant),
      .hit  (w_hit),
      .idx  (w_pick)
   );

   // Arbitration FSM: grant and latch in IDLE, strobe in REQ, relay ack in XFER, one-cycle gap in DONE.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state   <= ARB_IDLE;
         r_grant   <= drv_idx_t'(NDR - 1);
         r_lba     <= '0;
         r_host_rd <= 1'b0;
         r_host_wr <= 1'b0;
         r_abort   <= 1'b0;
         r_drv_ack <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               r_abort   <= 1'b0;
               r_drv_ack <= '0;
               if (w_hit) begin
                  r_grant   <= w_pick;
                  r_lba     <= w_lba_arr[w_pick];
                  r_host_wr <= w_pick_wr;
                  r_host_rd <= ~w_pick_wr;
                  r_state   <= ARB_REQ;
               end
            end
            ARB_REQ: begin
               r_abort <= w_abort;
               if (host_ack) begin
                  r_host_rd <= 1'b0;
                  r_host_wr <= 1'b0;
                  r_drv_ack <= w_ack_vec;
                  r_state   <= ARB_XFER;
               end
            end
            ARB_XFER: begin
               r_abort <= w_abort;
               if (host_ack) begin
                  r_drv_ack <= w_ack_vec;
               end else begin
                  r_drv_ack <= '0;
                  r_state   <= ARB_DONE;
               end
            end
            default: begin
               r_drv_ack <= '0;
               r_state   <= ARB_IDLE;
            end
         endcase
      end
   end

   assign drv_ack       = r_drv_ack;
   assign host_lba      = r_lba;
   assign host_rd       = r_host_rd;
   assign host_wr       = r_host_wr;
   assign busy          = (r_state != ARB_IDLE);
   assign host_buff_din = w_active ? w_din_arr[r_grant] : 8'hFF;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Directed bench for the SD arbiter: one line per host transaction, then a summary.
module tb_iecdrv_sd_arbiter;

   localparam int NDR   = 4;
   localparam int LBA_W = 32;

   logic                 clk_sys = 1'b0;
   logic                 reset;
   logic [NDR-1:0]       drv_reset;
   logic [NDR*LBA_W-1:0] drv_lba;
   logic [NDR-1:0]       drv_rd;
   logic [NDR-1:0]       drv_wr;
   logic [NDR-1:0]       drv_ack;
   logic [NDR*8-1:0]     drv_buff_din;
   logic [LBA_W-1:0]     host_lba;
   logic                 host_rd;
   logic                 host_wr;
   logic                 host_ack;
   logic [7:0]           host_buff_din;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   iecdrv_sd_arbiter #(
      .NDR   (NDR),
      .LBA_W (LBA_W)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .drv_reset     (drv_reset),
      .drv_lba       (drv_lba),
      .drv_rd        (drv_rd),
      .drv_wr        (drv_wr),
      .drv_ack       (drv_ack),
      .drv_buff_din  (drv_buff_din),
      .host_lba      (host_lba),
      .host_rd       (host_rd),
      .host_wr       (host_wr),
      .host_ack      (host_ack),
      .host_buff_din (host_buff_din),
      .busy          (busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic set_req(input int d, input logic rd, input logic wr, input logic [31:0] lba);
      drv_rd[d]              = rd;
      drv_wr[d]              = wr;
      drv_lba[d*LBA_W +: 32] = lba;
   endtask

   // Runs one full transaction starting in IDLE with the request already presented.
   task automatic serve(input string tag, input int d, input logic [31:0] lba, input logic wr,
                        input logic drop_rd, input logic drop_wr, input int req_wait, input int ack_len);
      int         bad;
      logic       exp_rd;
      logic [3:0] exp_ack;
      logic [7:0] exp_din;
      exp_rd  = ~wr;
      exp_ack = 4'b0001 << d;
      exp_din = 8'hD0 + 8'(d);
      step();
      chk({tag, "_lba"}, host_lba, lba);
      chk({tag, "_wr"}, host_wr, wr);
      chk({tag, "_rd"}, host_rd, exp_rd);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_din"}, host_buff_din, exp_din);
      bad = 0;
      for (int i = 0; i < req_wait; i++) begin
         step();
         if (host_rd !== exp_rd || host_wr !== wr || drv_ack !== 4'b0) bad++;
      end
      if (req_wait > 0) chk({tag, "_strobe_hold"}, bad, 0);
      host_ack = 1'b1;
      step();
      chk({tag, "_ack"}, drv_ack, exp_ack);
      chk({tag, "_strobe_off"}, {host_rd, host_wr}, 0);
      if (drop_rd) drv_rd[d] = 1'b0;
      if (drop_wr) drv_wr[d] = 1'b0;
      bad = 0;
      for (int i = 1; i < ack_len; i++) begin
         step();
         if (drv_ack !== exp_ack || host_rd !== 1'b0 || host_wr !== 1'b0) bad++;
      end
      if (ack_len > 1) chk({tag, "_ack_hold"}, bad, 0);
      host_ack = 1'b0;
      step();
      chk({tag, "_ack_fall"}, drv_ack, 0);
      chk({tag, "_busy_done"}, busy, 1);
      step();
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_lba_keep"}, host_lba, lba);
      chk({tag, "_din_idle"}, host_buff_din, 8'hFF);
      $display("xfer %s drive %0d lba %h %s", tag, d, lba, wr ? "wr" : "rd");
   endtask

   initial begin
      int bad;
      reset        = 1'b1;
      drv_reset    = '0;
      drv_lba      = '0;
      drv_rd       = '0;
      drv_wr       = '0;
      host_ack     = 1'b0;
      drv_buff_din = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
      step();
      step();
      chk("rst_rd", host_rd, 0);
      chk("rst_wr", host_wr, 0);
      chk("rst_ack", drv_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lba", host_lba, 0);
      chk("rst_din", host_buff_din, 8'hFF);
      reset = 1'b0;

      // Single read from drive 2, host_ack held for 512 clocks.
      set_req(2, 1'b1, 1'b0, 32'h123);
      serve("t1", 2, 32'h123, 1'b0, 1'b1, 1'b0, 2, 512);

      // Simultaneous requests from drives 0 and 3 straight out of reset.
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h1000);
      set_req(3, 1'b1, 1'b0, 32'h3000);
      serve("t2a", 0, 32'h1000, 1'b0, 1'b1, 1'b0, 0, 3);
      serve("t2b", 3, 32'h3000, 1'b0, 1'b1, 1'b0, 0, 3);

      // Drives 1..3 keep requesting: strict rotation 1,2,3,1,2,3.
      set_req(1, 1'b1, 1'b0, 32'h0000_0111);
      set_req(2, 1'b1, 1'b0, 32'h0000_0222);
      set_req(3, 1'b1, 1'b0, 32'h0000_0333);
      for (int r = 0; r < 2; r++) begin
         serve("t3_d1", 1, 32'h111, 1'b0, 1'b0, 1'b0, 0, 2);
         serve("t3_d2", 2, 32'h222, 1'b0, 1'b0, 1'b0, 0, 2);
         serve("t3_d3", 3, 32'h333, 1'b0, 1'b0, 1'b0, 0, 2);
      end
      drv_rd = '0;

      // Read and write together: write first, the read remains pending.
      set_req(0, 1'b1, 1'b1, 32'h10);
      serve("t4_wr", 0, 32'h10, 1'b1, 1'b0, 1'b1, 1, 2);
      serve("t4_rd", 0, 32'h10, 1'b0, 1'b1, 1'b0, 0, 2);

      // Drive 1 reset during its transaction: ack masked, host side completes.
      set_req(1, 1'b1, 1'b0, 32'h55);
      step();
      chk("t5_rd", host_rd, 1);
      chk("t5_lba", host_lba, 32'h55);
      drv_reset[1] = 1'b1;
      step();
      host_ack = 1'b1;
      step();
      chk("t5_ack_masked", drv_ack, 0);
      chk("t5_strobe_off", host_rd, 0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            drv_reset[1] = 1'b0;
            drv_rd[1]    = 1'b0;
         end
         step();
         if (drv_ack !== 4'b0 || busy !== 1'b1) bad++;
      end
      chk("t5_ack_hold0", bad, 0);
      host_ack = 1'b0;
      step();
      chk("t5_busy_done", busy, 1);
      step();
      chk("t5_busy_idle", busy, 0);
      $display("xfer t5 drive 1 lba %h rd aborted", 32'h55);

      // Asynchronous reset in the middle of a transfer.
      set_req(2, 1'b1, 1'b0, 32'h66);
      step();
      host_ack = 1'b1;
      step();
      chk("t6_ack_pre", drv_ack, 4'b0100);
      drv_rd[2] = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h77);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_ack", drv_ack, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_strobe", {host_rd, host_wr}, 0);
      chk("t6_rst_lba", host_lba, 0);
      chk("t6_rst_din", host_buff_din, 8'hFF);
      step();
      reset    = 1'b0;
      host_ack = 1'b0;
      serve("t6", 0, 32'h77, 1'b0, 1'b1, 1'b0, 0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
